// File: rtl/instr_mem.sv
// Instruction memory: a program is streamed in through the load port and then
// fetched with a registered, one-cycle-latency read. Out-of-range fetches return NOP.
module instr_mem #(
    parameter int            A   = 4,
    parameter int            W   = 9,
    parameter logic [W-1:0]  NOP = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [W-1:0]  load_data,
    input  logic          load_last,
    input  logic          fetch_en,
    input  logic          stall,
    input  logic [A-1:0]  inst_addr,
    output logic [W-1:0]  inst_out,
    output logic          inst_valid,
    output logic          oob,
    output logic [A:0]    prog_len,
    output logic          load_done
);

    localparam int DEPTH = 2**A;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_mem [DEPTH];
    logic [A-1:0]   r_wptr;
    logic [A:0]     r_len;
    logic [W-1:0]   r_inst_out;
    logic           r_inst_valid;
    logic           r_oob;

    logic           w_wr;
    logic           w_wr_end;
    logic           w_fetch_ok;
    logic           w_oob;

    // A restart in the same cycle as load_valid wins, so that word is dropped.
    assign w_wr       = (r_state == S_LOAD) && load_valid && !load_start;
    assign w_wr_end   = w_wr && (load_last || (r_wptr == {A{1'b1}}));
    assign w_fetch_ok = (r_state == S_READY) && !load_start;
    assign w_oob      = ({1'b0, inst_addr} >= r_len);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY: if (load_start) w_next = S_LOAD;
            S_LOAD: begin
                if (load_start)    w_next = S_LOAD;
                else if (w_wr_end) w_next = S_READY;
            end
            S_READY: if (load_start) w_next = S_LOAD;
            default: w_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_wptr  <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_next;
            if (load_start) begin
                r_wptr <= '0;
                r_len  <= '0;
            end else if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
                r_len  <= r_len + 1'b1;
            end
        end
    end

    // Memory has no reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_mem[r_wptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_out   <= '0;
            r_inst_valid <= 1'b0;
            r_oob        <= 1'b0;
        end else if (!w_fetch_ok) begin
            r_inst_valid <= 1'b0;
        end else if (stall) begin
            r_inst_valid <= r_inst_valid;
        end else if (fetch_en) begin
            r_inst_out   <= w_oob ? NOP : r_mem[inst_addr];
            r_oob        <= w_oob;
            r_inst_valid <= 1'b1;
        end else begin
            r_inst_valid <= 1'b0;
        end
    end

    assign inst_out   = r_inst_out;
    assign inst_valid = r_inst_valid;
    assign oob        = r_oob;
    assign prog_len   = r_len;
    assign load_done  = (r_state == S_READY);

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: a directed vector table, a full-depth load sequence,
// and randomized traffic compared against a program-level reference model.
module tb_instr_mem;

    logic       clk = 1'b0;
    logic       reset, load_start, load_valid, load_last, fetch_en, stall;
    logic [8:0] load_data;
    logic [3:0] inst_addr;
    logic [8:0] inst_out;
    logic       inst_valid, oob, load_done;
    logic [4:0] prog_len;

    int n_cmp = 0;
    int n_bad = 0;

    instr_mem #(.A(4), .W(9), .NOP(9'h000)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .fetch_en   (fetch_en),
        .stall      (stall),
        .inst_addr  (inst_addr),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .oob        (oob),
        .prog_len   (prog_len),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ls, lv;
        logic [8:0] d;
        logic       ll, fe, st;
        logic [3:0] addr;
        logic [8:0] e_out;
        logic       e_vld, e_oob;
        logic [4:0] e_len;
        logic       e_done;
    } vec_t;

    vec_t tbl [31];

    // Reference model: the program is a list of words, its length is the
    // number of accepted words since the last start.
    localparam int M_EMPTY = 0, M_LOAD = 1, M_READY = 2;
    int       m_mode = M_EMPTY;
    int       m_len  = 0;
    bit [8:0] m_mem [16];
    bit [8:0] m_out  = 0;
    bit       m_vld  = 0;
    bit       m_oob  = 0;

    function automatic vec_t mk(input logic rst, ls, lv, input logic [8:0] d,
                                input logic ll, fe, st, input logic [3:0] addr,
                                input logic [8:0] e_out, input logic e_vld, e_oob,
                                input logic [4:0] e_len, input logic e_done);
        vec_t v;
        v.rst = rst; v.ls = ls; v.lv = lv; v.d = d; v.ll = ll; v.fe = fe;
        v.st = st; v.addr = addr; v.e_out = e_out; v.e_vld = e_vld;
        v.e_oob = e_oob; v.e_len = e_len; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_update(input logic rst, ls, lv, input logic [8:0] d,
                                input logic ll, fe, st, input logic [3:0] addr);
        if (rst) begin
            m_mode = M_EMPTY; m_len = 0; m_out = 0; m_vld = 0; m_oob = 0;
        end else begin
            if (m_mode == M_READY && !ls) begin
                if (!st) begin
                    if (fe) begin
                        m_oob = (int'(addr) >= m_len);
                        m_out = m_oob ? 9'h000 : m_mem[addr];
                        m_vld = 1;
                    end else begin
                        m_vld = 0;
                    end
                end
            end else begin
                m_vld = 0;
            end
            if (ls) begin
                m_mode = M_LOAD;
                m_len  = 0;
            end else if (m_mode == M_LOAD && lv) begin
                m_mem[m_len] = d;
                m_len++;
                if (ll || m_len == 16) m_mode = M_READY;
            end
        end
    endtask

    task automatic step(input logic rst, ls, lv, input logic [8:0] d,
                        input logic ll, fe, st, input logic [3:0] addr);
        @(negedge clk);
        reset = rst; load_start = ls; load_valid = lv; load_data = d;
        load_last = ll; fetch_en = fe; stall = st; inst_addr = addr;
        @(posedge clk);
        #1;
        model_update(rst, ls, lv, d, ll, fe, st, addr);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " out"},  int'(inst_out),   int'(m_out));
        chk({tag, " vld"},  int'(inst_valid), int'(m_vld));
        chk({tag, " oob"},  int'(oob),        int'(m_oob));
        chk({tag, " len"},  int'(prog_len),   m_len);
        chk({tag, " done"}, int'(load_done),  int'(m_mode == M_READY));
    endtask

    initial begin
        reset = 1; load_start = 0; load_valid = 0; load_data = 0;
        load_last = 0; fetch_en = 0; stall = 0; inst_addr = 0;

        //           rst ls lv data    ll fe st addr   out     v  o  len done
        tbl[0]  = mk(1, 0, 0, 9'h000, 0, 0, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[1]  = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[2]  = mk(0, 1, 0, 9'h000, 0, 0, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[3]  = mk(0, 0, 1, 9'h101, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd1, 0);
        tbl[4]  = mk(0, 0, 1, 9'h0A2, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd2, 0);
        tbl[5]  = mk(0, 0, 1, 9'h1FF, 1, 0, 0, 4'd0, 9'h000, 0, 0, 5'd3, 1);
        tbl[6]  = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd1, 9'h0A2, 1, 0, 5'd3, 1);
        tbl[7]  = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd5, 9'h000, 1, 1, 5'd3, 1);
        tbl[8]  = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd0, 9'h101, 1, 0, 5'd3, 1);
        tbl[9]  = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd2, 9'h1FF, 1, 0, 5'd3, 1);
        tbl[10] = mk(0, 0, 0, 9'h000, 0, 1, 1, 4'd7, 9'h1FF, 1, 0, 5'd3, 1);
        tbl[11] = mk(0, 0, 0, 9'h000, 0, 1, 1, 4'd0, 9'h1FF, 1, 0, 5'd3, 1);
        tbl[12] = mk(0, 0, 0, 9'h000, 0, 1, 1, 4'd5, 9'h1FF, 1, 0, 5'd3, 1);
        tbl[13] = mk(0, 0, 0, 9'h000, 0, 0, 0, 4'd1, 9'h1FF, 0, 0, 5'd3, 1);
        tbl[14] = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd9, 9'h000, 1, 1, 5'd3, 1);
        tbl[15] = mk(0, 0, 0, 9'h000, 0, 0, 0, 4'd0, 9'h000, 0, 1, 5'd3, 1);
        tbl[16] = mk(0, 1, 0, 9'h000, 0, 1, 0, 4'd0, 9'h000, 0, 1, 5'd0, 0);
        tbl[17] = mk(0, 0, 1, 9'h033, 0, 0, 0, 4'd0, 9'h000, 0, 1, 5'd1, 0);
        tbl[18] = mk(0, 0, 1, 9'h044, 0, 0, 0, 4'd0, 9'h000, 0, 1, 5'd2, 0);
        tbl[19] = mk(0, 1, 1, 9'h055, 0, 0, 0, 4'd0, 9'h000, 0, 1, 5'd0, 0);
        tbl[20] = mk(0, 0, 1, 9'h066, 1, 0, 0, 4'd0, 9'h000, 0, 1, 5'd1, 1);
        tbl[21] = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd0, 9'h066, 1, 0, 5'd1, 1);
        tbl[22] = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd1, 9'h000, 1, 1, 5'd1, 1);
        tbl[23] = mk(0, 1, 0, 9'h000, 0, 0, 0, 4'd0, 9'h000, 0, 1, 5'd0, 0);
        tbl[24] = mk(0, 0, 1, 9'h077, 0, 1, 0, 4'd0, 9'h000, 0, 1, 5'd1, 0);
        tbl[25] = mk(1, 0, 1, 9'h088, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[26] = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[27] = mk(0, 0, 1, 9'h099, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[28] = mk(0, 1, 1, 9'h0AA, 0, 1, 0, 4'd0, 9'h000, 0, 0, 5'd0, 0);
        tbl[29] = mk(0, 0, 1, 9'h0BB, 1, 0, 0, 4'd0, 9'h000, 0, 0, 5'd1, 1);
        tbl[30] = mk(0, 0, 0, 9'h000, 0, 1, 0, 4'd0, 9'h0BB, 1, 0, 5'd1, 1);

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].rst, tbl[i].ls, tbl[i].lv, tbl[i].d, tbl[i].ll,
                 tbl[i].fe, tbl[i].st, tbl[i].addr);
            chk($sformatf("v%0d out", i),  int'(inst_out),   int'(tbl[i].e_out));
            chk($sformatf("v%0d vld", i),  int'(inst_valid), int'(tbl[i].e_vld));
            chk($sformatf("v%0d oob", i),  int'(oob),        int'(tbl[i].e_oob));
            chk($sformatf("v%0d len", i),  int'(prog_len),   int'(tbl[i].e_len));
            chk($sformatf("v%0d done", i), int'(load_done),  int'(tbl[i].e_done));
        end

        // Full-depth load without load_last: READY only after the 16th word.
        step(0, 1, 0, 9'h000, 0, 0, 0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 9'(9'h100 + i * 13), 0, 1, 0, 4'(i));
            chk($sformatf("full w%0d done", i), int'(load_done), int'(i == 15));
            chk($sformatf("full w%0d len", i),  int'(prog_len),  i + 1);
        end
        step(0, 0, 0, 9'h000, 0, 1, 0, 4'd15);
        chk("full a15 out", int'(inst_out), int'(9'(9'h100 + 15 * 13)));
        chk("full a15 oob", int'(oob), 0);
        chk("full a15 vld", int'(inst_valid), 1);
        step(0, 0, 0, 9'h000, 0, 1, 0, 4'd3);
        chk_model("full a3");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic rr, ls, lv, ll, fe, st;
            rr = ($urandom_range(0, 99) == 0);
            ls = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 1) == 1);
            ll = ($urandom_range(0, 7) == 0);
            fe = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 3) == 0);
            step(rr, ls, lv, 9'($urandom), ll, fe, st, 4'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter A, default 4, address width in bits; depth is 2**A words.
REQ-002 Parameter W, default 9, instruction width in bits.
REQ-003 Parameter NOP, default W'h000, word returned for out-of-range fetches.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_start  input  1  begin or restart a program load.
REQ-007 load_valid  input  1  load_data valid this cycle.
REQ-008 load_data  input  W  instruction word to store.
REQ-009 load_last  input  1  qualifies load_valid; marks final word.
REQ-010 fetch_en  input  1  request fetch of inst_addr.
REQ-011 stall  input  1  hold fetch output registers.
REQ-012 inst_addr  input  A  fetch address.
REQ-013 inst_out  output  W  registered instruction.
REQ-014 inst_valid  output  1  inst_out holds a fetched word.
REQ-015 oob  output  1  registered; last fetch address was >= prog_len.
REQ-016 prog_len  output  A+1  number of words in the loaded program.
REQ-017 load_done  output  1  high exactly while state is READY.

Function
REQ-018 Storage SHALL be a 2**A x W array; the read and write paths SHALL both be synchronous to clk.
REQ-019 FSM states SHALL be EMPTY, LOAD and READY.
REQ-020 EMPTY -> LOAD, and READY -> LOAD, SHALL occur on load_start; in the same edge the write pointer wptr SHALL be cleared to 0 and prog_len to 0.
REQ-021 In LOAD, load_valid SHALL write load_data to mem[wptr], increment wptr by 1 and increment prog_len by 1.
REQ-022 LOAD -> READY SHALL occur on the edge that accepts load_valid&load_last, or that writes address 2**A-1; in the latter case prog_len SHALL equal 2**A.
REQ-023 In LOAD, load_start SHALL restart the load (wptr=0, prog_len=0); load_data presented in that same cycle SHALL be discarded.
REQ-024 load_valid outside LOAD SHALL be ignored; load_start together with load_valid in EMPTY or READY SHALL enter LOAD and discard the data.
REQ-025 In READY, with stall=0 and fetch_en=1, the next edge SHALL load inst_out from mem[inst_addr] and set inst_valid=1 (1-cycle latency).
REQ-026 Such a fetch with inst_addr >= prog_len SHALL return inst_out=NOP with oob=1; an in-range fetch SHALL clear oob.
REQ-027 With stall=1, inst_out, inst_valid and oob SHALL hold; stall SHALL take priority over fetch_en.
REQ-028 With stall=0 and fetch_en=0, inst_valid SHALL go to 0 and inst_out and oob SHALL hold.
REQ-029 In EMPTY or LOAD, inst_valid SHALL be driven 0 on the next edge regardless of fetch_en or stall; inst_out SHALL hold.
REQ-030 A fetch in READY during the cycle load_start is asserted SHALL be ignored (inst_valid -> 0).
REQ-031 An address just written SHALL be readable by a fetch issued one cycle after READY is entered; no read-during-write hazard exists, because fetch is disabled during LOAD.

Reset
REQ-032 Reset SHALL force state=EMPTY, wptr=0, prog_len=0, inst_out=0, inst_valid=0, oob=0 and load_done=0.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 Reset asserted mid-load SHALL abort the load and return to EMPTY; reset SHALL dominate all other inputs.

Verification (A=4, W=9, NOP=0)
REQ-035 Load 0x101, 0x0A2, 0x1FF (last=1 on the third word) -> load_done=1 and prog_len=3; fetch addr 1 -> inst_out=0x0A2, inst_valid=1 next cycle.
REQ-036 After REQ-035, fetch addr 5 -> inst_out=0x000, oob=1, inst_valid=1; then fetch addr 0 -> inst_out=0x101, oob=0.
REQ-037 Load 16 words with load_last=0 -> READY after the 16th word, prog_len=16; fetch addr 15 returns the 16th word and oob=0.
REQ-038 Fetch addr 2, then hold stall=1 for 3 cycles while inst_addr changes -> inst_out stays 0x1FF and inst_valid stays 1.
REQ-039 After writing 2 words, assert load_start with load_valid=1 and load_data=0x055 -> prog_len=0 and the word is discarded; then assert reset -> EMPTY, outputs 0, and fetch gives inst_valid=0.
REQ-040 Fetch in EMPTY or LOAD with fetch_en=1 -> inst_valid stays 0 throughout.
